// File: rtl/uart_rx_word_packer_if.sv
// Stream bundle between the UART byte source, the word packer and the
// CPU-side consumer.
//
// Handshake: on both streams a transfer happens on a rising clk edge where
// tvalid and tready are both 1. The byte side has no back-pressure:
// s_tready is 1 whenever the packer is out of reset, and s_tvalid is a
// one-cycle strobe per byte. On the word side m_tvalid stays high, with
// m_tdata stable, until the consumer takes the word with m_tready.
interface uart_rx_word_packer_if;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;

  // Environment side: drives bytes, consumes words
  modport master (
    output s_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tvalid
  );

  // Packer side: accepts bytes, offers words
  modport slave (
    input  s_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tvalid
  );
endinterface

// File: rtl/uart_rx_word_packer.sv
// UART RX word packer: collects four received bytes into a 32-bit word
// (little-endian by default), queues completed words in a small FIFO and
// throws away a partial word when the inter-byte gap gets too long.
// Optional macro UART_RX_WORD_PACKER_BE_EN adds a swap_en input that
// selects big-endian lane order, latched when a word starts.
// fsm_state exposes the collector state (0 = IDLE, 1 = COLLECT).
module uart_rx_word_packer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 208334
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef UART_RX_WORD_PACKER_BE_EN
  input  logic                        swap_en,
`endif
  uart_rx_word_packer_if.slave        bus,
  output logic [1:0]                  byte_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        timeout,
  output logic [0:0]                  fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  // Collector state
  logic [0:0]    state_q;
  logic [1:0]    cnt_q;
  logic [TW-1:0] timer_q;
  logic [31:0]   shreg_q;
  logic          timeout_q;
  logic          s_tready_q;

  // FIFO state
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [LW-1:0] level_q;
  logic [31:0]   head_q;
  logic          overflow_q;

  // Combinational helpers
  logic          be_now;
  logic [1:0]    lane;
  logic [31:0]   word_next;
  logic          word_done;
  logic          timer_expire;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic [LW-1:0] level_next;
  logic [AW-1:0] rd_next;
  logic [31:0]   head_next;

`ifdef UART_RX_WORD_PACKER_BE_EN
  logic word_be_q;

  // Lane order follows swap_en on the first byte, then stays for the word
  always_comb begin
    be_now = (cnt_q == 2'd0) ? swap_en : word_be_q;
  end

  // Latch the lane order when a new word starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_be_q <= 1'b0;
    end else if (bus.s_tvalid && (cnt_q == 2'd0)) begin
      word_be_q <= swap_en;
    end
  end
`else
  // Little-endian only
  always_comb begin
    be_now = 1'b0;
  end
`endif

  // Place the incoming byte into its lane and derive FIFO control
  always_comb begin
    lane      = be_now ? (2'd3 - cnt_q) : cnt_q;
    word_next = shreg_q;
    word_next[8*lane +: 8] = bus.s_tdata;

    word_done    = bus.s_tvalid && (cnt_q == 2'd3);
    timer_expire = (state_q == ST_COLLECT) && !bus.s_tvalid && (timer_q == TIMER_LAST);

    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LEVEL_FULL);
    pop        = !fifo_empty && bus.m_tready;
    // A full FIFO still takes a word if the head leaves in the same cycle
    push_ok    = word_done && (!fifo_full || pop);
    drop       = word_done && fifo_full && !pop;
    level_next = level_q + LW'(push_ok) - LW'(pop);
    rd_next    = pop ? (rd_ptr_q + 1'b1) : rd_ptr_q;

    // Next registered head: bypass the incoming word when it lands at the
    // head of an otherwise empty FIFO, else read the slot rd_next points at
    if (level_next == '0) begin
      head_next = '0;
    end else if (push_ok && (level_q == LW'(pop))) begin
      head_next = word_next;
    end else begin
      head_next = mem[rd_next];
    end
  end

  // Byte collector: lane counter, inactivity timer and partial-word discard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      timer_q    <= '0;
      shreg_q    <= '0;
      timeout_q  <= 1'b0;
      s_tready_q <= 1'b0;
    end else begin
      s_tready_q <= 1'b1;
      timeout_q  <= timer_expire;
      if (bus.s_tvalid) begin
        // A byte always wins over an expiring timer
        timer_q <= '0;
        if (word_done) begin
          cnt_q   <= 2'd0;
          state_q <= ST_IDLE;
          shreg_q <= '0;
        end else begin
          cnt_q   <= cnt_q + 2'd1;
          state_q <= ST_COLLECT;
          shreg_q <= word_next;
        end
      end else if (timer_expire) begin
        cnt_q   <= 2'd0;
        state_q <= ST_IDLE;
        shreg_q <= '0;
        timer_q <= '0;
      end else if (state_q == ST_COLLECT) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because level gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= word_next;
    end
  end

  // FIFO pointers, level, registered head word and overflow pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      head_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_next;
      wr_ptr_q   <= push_ok ? (wr_ptr_q + 1'b1) : wr_ptr_q;
      level_q    <= level_next;
      head_q     <= head_next;
      overflow_q <= drop;
    end
  end

  assign bus.s_tready = s_tready_q;
  assign bus.m_tdata  = head_q;
  assign bus.m_tvalid = !fifo_empty;
  assign byte_cnt     = cnt_q;
  assign fifo_level   = level_q;
  assign overflow     = overflow_q;
  assign timeout      = timeout_q;
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Testbench for uart_rx_word_packer with a short timeout so the whole run
// stays small. Words expected at the output are queued as stimulus is
// issued; a negedge monitor pops and compares on every word handshake.
module tb_uart_rx_word_packer;

  localparam int DEPTH = 4;
  localparam int TMO   = 40;
  localparam int GAP   = TMO / 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_word_packer_if bus();
  logic [1:0] byte_cnt;
  logic [$clog2(DEPTH):0] fifo_level;
  logic overflow;
  logic timeout;
  logic [0:0] fsm_state;
`ifdef UART_RX_WORD_PACKER_BE_EN
  logic swap_en = 1'b0;
`endif

  uart_rx_word_packer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef UART_RX_WORD_PACKER_BE_EN
    .swap_en    (swap_en),
`endif
    .bus        (bus),
    .byte_cnt   (byte_cnt),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .timeout    (timeout),
    .fsm_state  (fsm_state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;
  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;
  int to_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Word monitor: every accepted output word must be the next expected one
  always @(negedge clk) begin
    if (!rst && bus.m_tvalid && bus.m_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected: got 0x%08h expected no word", bus.m_tdata);
      end else begin
        exp_w = exp_q.pop_front();
        if (bus.m_tdata !== exp_w) begin
          errors++;
          $display("FAIL word_data: got 0x%08h expected 0x%08h", bus.m_tdata, exp_w);
        end
      end
    end
  end

  // Pulse counters
  always @(negedge clk) begin
    if (!rst) begin
      if (overflow) ov_cnt++;
      if (timeout)  to_cnt++;
    end
  end

  // Run-time bound
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- driver tasks ----------------
  // One-cycle byte strobe; returns 1 time unit after the sampling edge
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.s_tdata  = b;
    bus.s_tvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_tvalid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit kept);
    if (kept) exp_q.push_back(w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  // Drain with bounded wait, then confirm everything expected came out
  task automatic drain(input string name);
    bus.m_tready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_level"}, 32'(fifo_level), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] ord_bytes [4];
  logic [1:0] ord_cnt   [4];

  initial begin
    bus.s_tdata  = 8'h00;
    bus.s_tvalid = 1'b0;
    bus.m_tready = 1'b0;
    ord_bytes = '{8'hBE, 8'hBE, 8'h94, 8'hF0};
    ord_cnt   = '{2'd1, 2'd2, 2'd3, 2'd0};

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_s_tready", 32'(bus.s_tready), 32'd0);
    check("rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    check("rst_m_tdata", bus.m_tdata, 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    check("rst_pulses", {30'd0, overflow, timeout}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("s_tready_after_rst", 32'(bus.s_tready), 32'd1);

    // Byte order, lane counter and first-word latency
    bus.m_tready = 1'b1;
    exp_q.push_back(32'hF094BEBE);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (GAP - 1) @(posedge clk);
      if (i == 3) check("order_no_valid_early", 32'(bus.m_tvalid), 32'd0);
      send_byte(ord_bytes[i]);
      check($sformatf("order_byte_cnt_%0d", i), 32'(byte_cnt), 32'(ord_cnt[i]));
      if (i == 0) check("order_state_collect", 32'(fsm_state), 32'd1);
    end
    check("order_m_tvalid", 32'(bus.m_tvalid), 32'd1);
    check("order_m_tdata", bus.m_tdata, 32'hF094BEBE);
    check("order_state_idle", 32'(fsm_state), 32'd0);
    drain("order");

    // Timeout discards a partial word
    send_byte(8'h1D);
    send_byte(8'hAB);
    repeat (TMO - 1) @(posedge clk); #1;
    check("tmo_before_cnt", 32'(byte_cnt), 32'd2);
    check("tmo_before_pulse", 32'(timeout), 32'd0);
    @(posedge clk); #1;
    check("tmo_cnt_cleared", 32'(byte_cnt), 32'd0);
    check("tmo_pulse", 32'(timeout), 32'd1);
    @(posedge clk); #1;
    check("tmo_pulse_single", 32'(timeout), 32'd0);
    send_word(32'h04030201, 1'b1);
    drain("after_tmo");
    check("tmo_pulse_count", 32'(to_cnt), 32'd1);

    // Byte arriving exactly as the timer expires wins
    send_byte(8'h55);
    repeat (TMO - 2) @(posedge clk);
    send_byte(8'h66);
    check("tie_byte_cnt", 32'(byte_cnt), 32'd2);
    check("tie_no_pulse", 32'(timeout), 32'd0);
    exp_q.push_back(32'h88776655);
    send_byte(8'h77);
    send_byte(8'h88);
    drain("tie");
    check("tie_pulse_count", 32'(to_cnt), 32'd1);

    // Overflow: fifth word dropped while the consumer is stalled
    bus.m_tready = 1'b0;
    send_word(32'h14131211, 1'b1);
    send_word(32'h24232221, 1'b1);
    send_word(32'h34333231, 1'b1);
    send_word(32'h44434241, 1'b1);
    check("ovf_level_full", 32'(fifo_level), 32'd4);
    check("ovf_none_yet", 32'(ov_cnt), 32'd0);
    send_word(32'h54535251, 1'b0);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_level_kept", 32'(fifo_level), 32'd4);
    check("ovf_head", bus.m_tdata, 32'h14131211);
    @(posedge clk); #1;
    check("ovf_pulse_single", 32'(overflow), 32'd0);
    drain("ovf");
    check("ovf_pulse_count", 32'(ov_cnt), 32'd1);

    // Push and pop together while full
    bus.m_tready = 1'b0;
    send_word(32'hA3A2A1A0, 1'b1);
    send_word(32'hB3B2B1B0, 1'b1);
    send_word(32'hC3C2C1C0, 1'b1);
    send_word(32'hD3D2D1D0, 1'b1);
    send_byte(8'hE0);
    send_byte(8'hE1);
    send_byte(8'hE2);
    exp_q.push_back(32'hE3E2E1E0);
    @(posedge clk); #1;
    bus.s_tdata  = 8'hE3;
    bus.s_tvalid = 1'b1;
    bus.m_tready = 1'b1;
    @(posedge clk); #1;
    bus.s_tvalid = 1'b0;
    bus.m_tready = 1'b0;
    check("fullpp_level", 32'(fifo_level), 32'd4);
    check("fullpp_no_ovf", 32'(overflow), 32'd0);
    check("fullpp_head", bus.m_tdata, 32'hB3B2B1B0);
    drain("fullpp");
    check("fullpp_ovf_count", 32'(ov_cnt), 32'd1);

    // Asynchronous reset mid-word with words queued
    bus.m_tready = 1'b0;
    send_word(32'h0F0E0D0C, 1'b1);
    send_word(32'h1F1E1D1C, 1'b1);
    send_byte(8'h2C);
    send_byte(8'h2D);
    #2;
    rst = 1'b1;
    #1;
    check("arst_byte_cnt", 32'(byte_cnt), 32'd0);
    check("arst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    check("arst_fifo_level", 32'(fifo_level), 32'd0);
    check("arst_s_tready", 32'(bus.s_tready), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    bus.m_tready = 1'b1;
    send_word(32'h7B6A5948, 1'b1);
    drain("arst");
    check("final_ovf_count", 32'(ov_cnt), 32'd1);
    check("final_tmo_count", 32'(to_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
